enc_par_serializer: RTL

//  Downstream of the parity buffer: snapshots the RSC_PAR_LEN parity symbols held in par_buf_data
//  and streams them out ENC_PAR_SER_WID symbols per beat on a valid/ready interface.

---
 rtl/enc_par_serializer_pkg.sv | 31 +++
 rtl/enc_par_serializer_sat_counter.sv | 32 +++
 rtl/enc_par_serializer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/enc_par_serializer_pkg.sv
// ---------------------------------------------------------------------------
// enc_par_serializer_pkg
// Shared constants and types for the parity serializer slice.
//   RSC_PAR_LEN       number of parity symbols per codeword block
//   EGF_DIM           bits per Galois-field symbol
//   ENC_PAR_BUF_DEP   depth of the upstream parity buffer
//   ENC_PAR_SER_WID   default symbols per output beat
//   ENC_PAR_SER_BEATS beats needed to send one parity block at the default width
// ---------------------------------------------------------------------------
package enc_par_serializer_pkg;

   localparam int RSC_PAR_LEN     = 16;
   localparam int EGF_DIM         = 8;
   localparam int ENC_PAR_BUF_DEP = 16;
   localparam int ENC_PAR_SER_WID = 4;

   // Integer ceiling division, used to size the beat count for any lane width.
   function automatic int enc_ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   localparam int ENC_PAR_SER_BEATS = enc_ceil_div(RSC_PAR_LEN, ENC_PAR_SER_WID);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } enc_par_ser_state_t;

   typedef logic [EGF_DIM-1:0] egf_sym_t;

endpackage

// File: rtl/enc_par_serializer_sat_counter.sv
// ---------------------------------------------------------------------------
// enc_sat_counter
// Saturating event counter: counts inc pulses up to all-ones and holds there.
//   clk    clock
//   rst_n  async active-low reset, clears the count
//   inc    count one event this cycle
//   clr    synchronous clear (takes priority over inc)
//   cnt    current count
// ---------------------------------------------------------------------------
module enc_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   // Count up on each event but stop at all-ones so the value never wraps
   // back to a small, misleading number.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/enc_par_serializer.sv
// ---------------------------------------------------------------------------
// enc_par_serializer
// Snapshots the parity block from the parity buffer and streams it out
// SER_WID symbols per beat over valid/ready, highest-degree symbol first.
// The local snapshot lets the parity buffer accept the next codeword while
// this block is still draining.
//   clk            clock
//   rst_n          async active-low reset
//   par_buf_start  pulse: par_buf_data holds a new parity block
//   par_buf_data   parity symbols from the parity buffer
//   ser_ready      downstream accepts the current beat
//   ser_valid      beat on ser_data is valid
//   ser_data       beat symbols, lane 0 first on the wire
//   ser_keep       lane-valid mask, all-ones except a partial last beat
//   ser_last       final beat of the block
//   ser_busy       a block is in flight
//   ser_ovf        sticky: a start arrived while busy and was dropped
// Optional build macro ENC_PAR_SER_STAT_EN adds saturating statistics:
//   ser_blk_cnt    blocks completed
//   ser_ovf_cnt    starts dropped while busy
// ---------------------------------------------------------------------------
module enc_par_serializer
   import enc_par_serializer_pkg::*;
#(
   parameter int SER_WID = ENC_PAR_SER_WID
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              par_buf_start,
   input  logic [ENC_PAR_BUF_DEP-1:0][EGF_DIM-1:0] par_buf_data,
   input  logic                              ser_ready,
   output logic                              ser_valid,
   output logic [SER_WID-1:0][EGF_DIM-1:0]   ser_data,
   output logic [SER_WID-1:0]                ser_keep,
   output logic                              ser_last,
   output logic                              ser_busy,
   output logic                              ser_ovf
`ifdef ENC_PAR_SER_STAT_EN
   ,
   output logic [15:0]                       ser_blk_cnt,
   output logic [15:0]                       ser_ovf_cnt
`endif
);

   localparam int BEATS  = enc_ceil_div(RSC_PAR_LEN, SER_WID);
   localparam int CNT_W  = $clog2(BEATS + 1);
   localparam int SYM_IW = $clog2(RSC_PAR_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   enc_par_ser_state_t           state;
   logic [CNT_W-1:0]             beat_cnt;
   egf_sym_t [RSC_PAR_LEN-1:0]   snapshot;
   logic                         last_beat;
   logic                         final_hs;
   logic                         drop_start;

   // A block ends on the handshake of its last beat; a start on any other
   // SEND cycle cannot be honoured without corrupting the block in flight.
   assign last_beat  = (beat_cnt == LAST_BEAT);
   assign final_hs   = (state == SEND) && ser_ready && last_beat;
   assign drop_start = (state == SEND) && par_buf_start && !final_hs;

   assign ser_valid = (state == SEND);
   assign ser_busy  = (state == SEND);
   assign ser_last  = (state == SEND) && last_beat;

   // Control FSM. A start coinciding with the final handshake reloads the
   // snapshot and stays in SEND, giving back-to-back blocks with no idle beat.
   // beat_cnt is parked at zero in IDLE so it never sits past the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         beat_cnt <= '0;
         snapshot <= '0;
         ser_ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (par_buf_start) begin
                  state    <= SEND;
                  snapshot <= par_buf_data[RSC_PAR_LEN-1:0];
                  beat_cnt <= '0;
               end
            end
            SEND: begin
               if (ser_ready) begin
                  if (last_beat) begin
                     beat_cnt <= '0;
                     if (par_buf_start) begin
                        snapshot <= par_buf_data[RSC_PAR_LEN-1:0];
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               beat_cnt <= '0;
            end
         endcase
         if (drop_start) begin
            ser_ovf <= 1'b1;
         end
      end
   end

   // Lane select: beat k, lane j carries symbol RSC_PAR_LEN-1-(k*SER_WID+j)
   // so the highest-degree parity leaves first. Lanes past the end of the
   // block on a partial last beat are zeroed and masked off in ser_keep.
   // Everything is zero outside SEND so the bus is quiet between blocks.
   always_comb begin
      ser_data = '0;
      ser_keep = '0;
      if (state == SEND) begin
         for (int j = 0; j < SER_WID; j++) begin
            if ((int'(beat_cnt) * SER_WID + j) < RSC_PAR_LEN) begin
               ser_data[j] = snapshot[SYM_IW'(RSC_PAR_LEN - 1 - (int'(beat_cnt) * SER_WID + j))];
               ser_keep[j] = 1'b1;
            end
         end
      end
   end

`ifdef ENC_PAR_SER_STAT_EN
   // Completed-block and dropped-start statistics, both saturating.
   enc_sat_counter #(.CNT_W(16)) u_blk_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (final_hs),
      .clr   (1'b0),
      .cnt   (ser_blk_cnt)
   );

   enc_sat_counter #(.CNT_W(16)) u_ovf_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (drop_start),
      .clr   (1'b0),
      .cnt   (ser_ovf_cnt)
   );
`endif

endmodule
